// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged sync FIFO.
// Pointer sizing, output mode constants, flag bundle.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for the flagged sync FIFO.
// master drives requests, slave is the FIFO itself.
interface sync_fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);

  localparam int CW = clog2(DEPTH) + 1;

  logic          wr_en;
  logic [WIDTH-1:0] din;
  logic          rd_en;
  logic          flush;
  logic          clear_err;
  logic [WIDTH-1:0] dout;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output wr_en, din, rd_en,
    output flush, clear_err,
    input  dout, empty, full,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    input  flush, clear_err,
    output dout, empty, full,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Dual-port storage: sync write, async read.
// Kept separate so a vendor RAM can drop in.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage needs no reset; contents are don't-care.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, threshold flags,
// flush, sticky errors and optional fall-through.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_flags_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0))
  begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "AF_LEVEL exceeds DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $fatal(1, "AE_LEVEL must be below DEPTH");
  end
  if (WIDTH < 1) begin : g_bad_w
    $fatal(1, "WIDTH must be at least 1");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cnt;
  logic          ovf;
  logic          udf;
  logic          wr_acc;
  logic          rd_acc;
  logic          we;
  logic [WIDTH-1:0] rdata;
  fifo_flags_t   flags;

  // Flags come straight off registered state.
  always_comb begin
    flags = '0;
    flags.empty = (wr_ptr == rd_ptr);
    flags.full  =
      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
      (wr_ptr[AW] != rd_ptr[AW]);
    flags.almost_empty = (cnt <= AE_L);
    flags.almost_full  = (cnt >= AF_L);
  end

  // A read frees a slot, so full+read admits a write.
  assign rd_acc = bus.rd_en & ~flags.empty;
  assign wr_acc = bus.wr_en &
                  (~flags.full | rd_acc);
  assign we     = wr_acc & ~bus.flush;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // Pointer and occupancy tracking; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky errors; a fresh error beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (!bus.flush && bus.wr_en && !wr_acc)
        ovf <= 1'b1;
      else if (bus.clear_err)
        ovf <= 1'b0;
      if (!bus.flush && bus.rd_en && !rd_acc)
        udf <= 1'b1;
      else if (bus.clear_err)
        udf <= 1'b0;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word shows through whenever present.
    assign bus.dout = flags.empty ? '0 : rdata;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    // Registered read: load on an accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        dout_q <= '0;
      else if (bus.flush)
        dout_q <= '0;
      else if (rd_acc)
        dout_q <= rdata;
    end

    assign bus.dout = dout_q;
  end

  assign bus.empty        = flags.empty;
  assign bus.full         = flags.full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: std and FWFT instances.
// Vector table plus data scoreboard and corner cases.
module tb_sync_fifo_flags;

  logic clk;
  logic rst_n;

  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(8)) bs ();
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(8)) bf ();

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(8), .FWFT(0),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  sync_fifo_flags #(
    .WIDTH(8), .DEPTH(8), .FWFT(1),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_fw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ae;
    logic       af;
    logic       ovf;
  } vec_t;

  vec_t       tv [9];
  logic [7:0] wv [12];
  logic [7:0] sb [$];
  logic [7:0] exp_d;
  int         nchk;
  int         nerr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bs.wr_en = 0; bs.rd_en = 0;
    bs.flush = 0; bs.clear_err = 0;
    bf.wr_en = 0; bf.rd_en = 0;
    bf.flush = 0; bf.clear_err = 0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " s.count"}, bs.count, 0);
    chk({tag, " s.empty"}, bs.empty, 1);
    chk({tag, " s.full"}, bs.full, 0);
    chk({tag, " s.ae"}, bs.almost_empty, 1);
    chk({tag, " s.af"}, bs.almost_full, 0);
    chk({tag, " s.ovf"}, bs.overflow, 0);
    chk({tag, " s.udf"}, bs.underflow, 0);
    chk({tag, " s.dout"}, bs.dout, 0);
    chk({tag, " f.count"}, bf.count, 0);
    chk({tag, " f.empty"}, bf.empty, 1);
    chk({tag, " f.udf"}, bf.underflow, 0);
    chk({tag, " f.dout"}, bf.dout, 0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    tv[0] = '{1, 8'hAA, 1, 0, 0, 1, 0, 0};
    tv[1] = '{1, 8'h4B, 2, 0, 0, 1, 0, 0};
    tv[2] = '{1, 8'h3B, 3, 0, 0, 0, 0, 0};
    tv[3] = '{1, 8'hC9, 4, 0, 0, 0, 0, 0};
    tv[4] = '{1, 8'h23, 5, 0, 0, 0, 0, 0};
    tv[5] = '{1, 8'hFE, 6, 0, 0, 0, 1, 0};
    tv[6] = '{1, 8'h7B, 7, 0, 0, 0, 1, 0};
    tv[7] = '{1, 8'h5E, 8, 0, 1, 0, 1, 0};
    tv[8] = '{1, 8'h64, 8, 0, 1, 0, 1, 1};
    wv = '{8'h64, 8'hC5, 8'h2B, 8'h91,
           8'h0F, 8'h7A, 8'hE3, 8'h48,
           8'hB6, 8'h1D, 8'hD2, 8'h59};

    idle();
    bs.din = 0;
    bf.din = 0;
    rst_n = 0;
    repeat (3) cyc();
    chk_rst("reset");
    rst_n = 1;
    cyc();

    // fill plus one rejected write
    for (int i = 0; i < 9; i++) begin
      bs.wr_en = tv[i].wr;
      bs.din   = tv[i].din;
      if (i < 8) sb.push_back(tv[i].din);
      cyc();
      chk($sformatf("v%0d count", i),
          bs.count, tv[i].cnt);
      chk($sformatf("v%0d empty", i),
          bs.empty, tv[i].emp);
      chk($sformatf("v%0d full", i),
          bs.full, tv[i].ful);
      chk($sformatf("v%0d ae", i),
          bs.almost_empty, tv[i].ae);
      chk($sformatf("v%0d af", i),
          bs.almost_full, tv[i].af);
      chk($sformatf("v%0d ovf", i),
          bs.overflow, tv[i].ovf);
    end
    idle();

    // drain in order
    for (int i = 0; i < 8; i++) begin
      bs.rd_en = 1;
      exp_d = sb.pop_front();
      cyc();
      chk($sformatf("drain%0d dout", i),
          bs.dout, exp_d);
      chk($sformatf("drain%0d count", i),
          bs.count, 7 - i);
    end
    idle();
    chk("drain empty", bs.empty, 1);
    chk("drain ovf held", bs.overflow, 1);
    bs.clear_err = 1;
    cyc();
    idle();
    chk("clr ovf", bs.overflow, 0);

    // refill, then full-boundary concurrency
    for (int i = 0; i < 8; i++) begin
      bs.wr_en = 1;
      bs.din = 8'h10 + 8'(i);
      sb.push_back(bs.din);
      cyc();
    end
    idle();
    chk("refill full", bs.full, 1);
    for (int i = 0; i < 12; i++) begin
      bs.wr_en = 1;
      bs.rd_en = 1;
      bs.din = wv[i];
      sb.push_back(wv[i]);
      exp_d = sb.pop_front();
      cyc();
      chk($sformatf("wrap%0d dout", i),
          bs.dout, exp_d);
      chk($sformatf("wrap%0d count", i),
          bs.count, 8);
      chk($sformatf("wrap%0d full", i),
          bs.full, 1);
      chk($sformatf("wrap%0d ovf", i),
          bs.overflow, 0);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      bs.rd_en = 1;
      exp_d = sb.pop_front();
      cyc();
      chk($sformatf("wdrain%0d dout", i),
          bs.dout, exp_d);
    end
    idle();
    chk("wdrain empty", bs.empty, 1);

    // empty-boundary concurrency
    bs.wr_en = 1;
    bs.rd_en = 1;
    bs.din = 8'h22;
    sb.push_back(8'h22);
    cyc();
    idle();
    chk("ebnd count", bs.count, 1);
    chk("ebnd udf", bs.underflow, 1);
    chk("ebnd empty", bs.empty, 0);

    // flush with 5 entries, udf still set
    for (int i = 0; i < 4; i++) begin
      bs.wr_en = 1;
      bs.din = 8'hA0 + 8'(i);
      cyc();
    end
    idle();
    chk("pre-flush count", bs.count, 5);
    bs.flush = 1;
    bs.wr_en = 1;
    bs.din = 8'h99;
    cyc();
    idle();
    sb.delete();
    chk("flush count", bs.count, 0);
    chk("flush empty", bs.empty, 1);
    chk("flush ae", bs.almost_empty, 1);
    chk("flush dout", bs.dout, 0);
    chk("flush udf kept", bs.underflow, 1);
    chk("flush ovf", bs.overflow, 0);
    bs.clear_err = 1;
    cyc();
    idle();
    chk("clr udf", bs.underflow, 0);

    // fall-through mode
    chk("fw idle dout", bf.dout, 0);
    bf.wr_en = 1;
    bf.din = 8'h35;
    cyc();
    bf.din = 8'h7C;
    cyc();
    idle();
    chk("fw count", bf.count, 2);
    chk("fw head", bf.dout, 8'h35);
    chk("fw not empty", bf.empty, 0);
    bf.rd_en = 1;
    cyc();
    chk("fw next", bf.dout, 8'h7C);
    cyc();
    idle();
    chk("fw empty", bf.empty, 1);
    chk("fw dout0", bf.dout, 0);
    chk("fw udf", bf.underflow, 0);

    // first word alone: visible next cycle
    bf.wr_en = 1;
    bf.din = 8'h35;
    cyc();
    idle();
    chk("fw1 dout", bf.dout, 8'h35);
    chk("fw1 empty", bf.empty, 0);

    // populate std with errors, then async reset
    bs.rd_en = 1;
    cyc();
    idle();
    chk("udf again", bs.underflow, 1);
    for (int i = 0; i < 7; i++) begin
      bs.wr_en = 1;
      bs.din = 8'h50 + 8'(i);
      cyc();
    end
    idle();
    bs.rd_en = 1;
    cyc();
    idle();
    chk("pre-rst count", bs.count, 6);
    chk("pre-rst af", bs.almost_full, 1);
    chk("pre-rst dout", bs.dout, 8'h50);
    #3;
    rst_n = 0;
    #1;
    chk_rst("async");
    @(negedge clk);
    rst_n = 1;
    cyc();
    chk("post-rst count", bs.count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Next-generation synchronous FIFO: single clock, parametrised width and depth (depth is a power of two).
- Selectable output mode: registered (standard) or first-word-fall-through (FWFT).
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Used as the general buffering element between producer/consumer stages in the datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- din  in  WIDTH  write data
- rd_en  in  1  read request (FWFT: acknowledge/pop of the head word)
- flush  in  1  synchronous clear of contents
- clear_err  in  1  synchronous clear of sticky error flags
- dout  out  WIDTH  read data
- empty  out  1  no entries
- full  out  1  DEPTH entries
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-transfer):
  - Pointers and count go to 0; dout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - overflow = 0, underflow = 0.
  - Memory contents are don't-care.
- Pointers: read and write pointers are $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - Wrap from DEPTH-1 to 0 is natural binary rollover.
- Acceptance:
  - wr_acc = wr_en & (!full | rd_acc).
  - rd_acc = rd_en & !empty.
- Simultaneous read and write:
  - Full: both accepted; count unchanged; full stays 1.
  - Empty: write accepted, read rejected (underflow set); count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count update: count + wr_acc - rd_acc, every edge. All flags derive from the registered count and pointers, so they are valid in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On an edge with rd_acc, dout loads mem[rd_ptr]; read latency is 1 cycle.
  - dout holds its value when there is no accepted read.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally whenever !empty; dout = 0 when empty.
  - The first word written to an empty FIFO is visible on dout the cycle after the write edge.
  - rd_acc advances to the next word.
- Errors:
  - overflow sets on wr_en & !wr_acc; underflow sets on rd_en & !rd_acc.
  - Both stay set until clear_err = 1 at an edge.
  - If a new error and clear_err occur in the same cycle, the flag stays set (set wins).
- flush:
  - At the edge, pointers and count become 0 and flags go to their reset values; error flags are unaffected.
  - Any wr_en/rd_en in the same cycle are ignored and do not raise errors.
  - dout = 0 after flush.
- Priority: rst_n > flush > normal operation.
- Elaboration: DEPTH not a power of two, AF_LEVEL > DEPTH, or AE_LEVEL >= DEPTH is a fatal elaboration error.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2 for pointer/count widths;
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1 constants;
  - a struct or typedef for the flag bundle {empty, full, almost_empty, almost_full}.
- One sub-module, fifo_mem: a WIDTH x DEPTH dual-port RAM with synchronous write and asynchronous read, so it can be swapped for a vendor RAM.
- Pointer, count, flag and error logic stay in sync_fifo_flags.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless stated):
- Reset and fill:
  - Stimulus: assert rst_n=0, release, then write 0xAA, 0x4B, 0x3B, 0xC9, 0x23, 0xFE, 0x7B, 0x5E.
  - Required: count steps 1..8; almost_empty drops when count=3; almost_full rises when count=6; full=1 after the 8th write.
- Overflow and drain:
  - Stimulus: at full, write 0x64; then read 8 times (FWFT=0).
  - Required: overflow=1 and count stays 8 after the rejected write; dout yields 0xAA..0x5E in order, each 1 cycle after rd_en; empty=1 at the end.
- Wrap and full-boundary concurrency:
  - Stimulus: fill to 8, then assert rd_en and wr_en together for 12 cycles with din=0x64, 0xC5, 0x2B, ...
  - Required: count stays 8, full stays 1, no overflow; the read sequence continues in order across pointer wrap.
- Empty-boundary concurrency:
  - Stimulus: on an empty FIFO, assert wr_en=1 (din=0x22) and rd_en=1 in the same cycle.
  - Required: count=1, underflow=1; pulse clear_err, then underflow=0.
- FWFT mode (FWFT=1):
  - Stimulus: write 0x35 into an empty FIFO.
  - Required: dout=0x35 and empty=0 the next cycle with no rd_en; one rd_en gives empty=1 and dout=0.
- Flush and async reset:
  - Stimulus: with 5 entries, assert flush together with wr_en.
  - Required: count=0 and empty=1 at the next edge; error flags unchanged.
  - Stimulus: then drop rst_n mid-cycle.
  - Required: all outputs go to reset values immediately, without waiting for a clock edge.
